// File: rtl/adder_sum_accumulator_pkg.sv
// Shared definitions for the adder result path: state encodings and default widths.
package adder_sum_accumulator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int N_DEF     = 32;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/adder_sum_accumulator.sv
// Accumulates BLOCK_LEN adder results {cout, s} into a wide block total.
// Result appears 1 cycle after the closing sample; held until out_ready, input stalled meanwhile.
module adder_sum_accumulator
  import adder_sum_accumulator_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     s,
  input  logic             cout,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_carry
);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_carry_q, out_carry_d;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] new_cnt;
  logic             new_carry;

  // Handshake outputs come straight from state so neither depends on any input.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_acc   = out_acc_q;
  assign out_count = out_cnt_q;
  assign out_carry = out_carry_q;

  assign accept    = in_valid && in_ready;
  assign sample    = ACC_W'({cout, s});
  assign sum       = acc_q + (accept ? sample : '0);
  assign new_cnt   = cnt_q + CNT_W'(accept);
  assign new_carry = carry_q | (accept & cout);
  // new_cnt is non-zero whenever a sample lands, so a bare flush on an empty block is dropped.
  assign close     = (state_q == ST_ACCUM) &&
                     ((accept && (new_cnt == CNT_W'(BLOCK_LEN))) || (flush && (new_cnt != '0)));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_carry_d = out_carry_q;
    if (clr) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      carry_d     = 1'b0;
      out_acc_d   = '0;
      out_cnt_d   = '0;
      out_carry_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ACCUM;
        ST_ACCUM: begin
          if (close) begin
            out_acc_d   = sum;
            out_cnt_d   = new_cnt;
            out_carry_d = new_carry;
            acc_d       = '0;
            cnt_d       = '0;
            carry_d     = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d   = sum;
            cnt_d   = new_cnt;
            carry_d = new_carry;
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_ACCUM;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_carry_q <= out_carry_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Self-checking bench for adder_sum_accumulator; inputs driven and outputs sampled on the falling edge.
module tb_adder_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, cout, flush, out_valid, out_ready, out_carry;
  logic [31:0] s;
  logic [40:0] out_acc;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  // Reference: block total is plain arithmetic over the samples pushed so far.
  longint unsigned m_total;
  int              m_count;
  logic            m_carry;

  always #5 clk = ~clk;

  adder_sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_carry(out_carry)
  );

  function automatic logic [50:0] exp_result();
    return {1'b1, 41'(m_total), 8'(m_count), m_carry};
  endfunction

  task automatic model_clear();
    m_total = 0;
    m_count = 0;
    m_carry = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one sample for exactly one edge.
  task automatic drive_sample(input logic [31:0] sv, input logic cv, input logic fl);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got %b exp 1", in_ready);
    end
    s = sv; cout = cv; flush = fl; in_valid = 1'b1;
    m_total += longint'(cv) * 64'h1_0000_0000 + longint'(sv);
    m_count++;
    m_carry |= cv;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL after_take got rdy/vld %b exp 10", {in_ready, out_valid});
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; s = '0; cout = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({in_ready, out_valid, out_acc, out_count, out_carry} !== 52'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", {in_ready, out_valid, out_acc, out_count, out_carry});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_rdy got %b exp 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accum_rdy got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) drive_sample(32'(i), 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd10, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd10, 8'd4, 1'b0});
    end
    take_result();
  endtask

  task automatic test_carry();
    for (int i = 0; i < 4; i++) drive_sample(32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'h7_FFFF_FFFC, 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL carry_max got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'h7_FFFF_FFFC, 8'd4, 1'b1});
    end
  endtask

  // Entered still holding the carry block result.
  task automatic test_backpressure();
    logic [50:0] held;
    held = {out_valid, out_acc, out_count, out_carry};
    s = 32'd99; cout = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_acc, out_count, out_carry} !== {1'b0, 1'b1, 41'h7_FFFF_FFFC, 8'd4, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold got %h exp %h", {in_ready, out_valid, out_acc, out_count, out_carry}, {1'b0, held});
      end
    end
    in_valid = 1'b0;
    take_result();
    drive_sample(32'd21, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd21, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL fresh_block got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd21, 8'd1, 1'b0});
    end
    take_result();
  endtask

  task automatic test_flush();
    drive_sample(32'd5, 1'b0, 1'b0);
    drive_sample(32'd7, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd12, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL flush_alone got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd12, 8'd2, 1'b0});
    end
    take_result();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL flush_empty got vld/rdy %b exp 01", {out_valid, in_ready});
      end
    end
    drive_sample(32'd6, 1'b0, 1'b0);
    drive_sample(32'd9, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd15, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL flush_same_edge got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd15, 8'd2, 1'b0});
    end
  endtask

  // Entered in HOLD with the 6+9 block still presented.
  task automatic test_clr();
    clr = 1'b1; in_valid = 1'b1; s = 32'd50; flush = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_acc, out_count, out_carry} !== {1'b1, 51'd0}) begin
      errors++;
      $display("FAIL clr_hold got %h exp %h", {in_ready, out_valid, out_acc, out_count, out_carry}, {1'b1, 51'd0});
    end
    model_clear();
    for (int i = 0; i < 4; i++) drive_sample(32'd1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd4, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL clr_then_ones got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd4, 8'd4, 1'b0});
    end
    take_result();
  endtask

  task automatic test_midblock_reset();
    drive_sample(32'd100, 1'b1, 1'b0);
    drive_sample(32'd200, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_acc, out_count, out_carry} !== 52'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {in_ready, out_valid, out_acc, out_count, out_carry});
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", in_ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_sample(32'd1000 + 32'(i), 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_acc, out_count, out_carry} !== {1'b1, 41'd4006, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_block got %h exp %h", {out_valid, out_acc, out_count, out_carry}, {1'b1, 41'd4006, 8'd4, 1'b0});
    end
    take_result();
  endtask

  task automatic test_random();
    for (int b = 0; b < 30; b++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        drive_sample($urandom, 1'($urandom_range(0, 1)), (i == len - 1) && (len < 4));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if ({out_valid, out_acc, out_count, out_carry} !== exp_result()) begin
        errors++;
        $display("FAIL random_block%0d got %h exp %h", b, {out_valid, out_acc, out_count, out_carry}, exp_result());
      end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_flush();
    test_clr();
    test_midblock_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
